// File: rtl/prt_dual_port.sv
// prt_dual_port: packet reference table with NUM_SLOTS frame buffers and
// independent write (allocate + stream in) and read (select + stream out)
// channels, plus a constant-time invalidate that frees a slot without
// clearing its memory.
//
// Optional build macro: PRT_AUTO_RELEASE_EN -- when defined, the last-beat
// read handshake frees the slot (READING->FREE); otherwise the slot returns
// to VALID and can be re-read until it is invalidated.
//
// Ports:
//   CLK, RST_N                     clock, async active-low reset
//   wr_start_valid/ready/slot      slot allocation (lowest free slot)
//   wr_data_valid/ready, wr_data, wr_last, wr_overflow
//                                  write beat stream; overflow pulses when
//                                  a frame is truncated at MEM_DEPTH beats
//   rd_start_valid/ready/slot      read request for a VALID slot
//   rd_data_valid/ready, rd_data, rd_last, rd_len
//                                  read beat stream and latched frame length
//   inv_valid/ready, inv_slot      invalidate a VALID slot
//   free_count, valid_mask         registered slot occupancy summary
module prt_dual_port #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 1518,
  parameter int unsigned NUM_SLOTS  = 4,
  localparam int unsigned SW = $clog2(NUM_SLOTS),
  localparam int unsigned LW = $clog2(MEM_DEPTH + 1),
  localparam int unsigned CW = $clog2(NUM_SLOTS + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  wr_start_valid,
  output logic                  wr_start_ready,
  output logic [SW-1:0]         wr_start_slot,
  input  logic                  wr_data_valid,
  output logic                  wr_data_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  wr_overflow,
  input  logic                  rd_start_valid,
  output logic                  rd_start_ready,
  input  logic [SW-1:0]         rd_start_slot,
  output logic                  rd_data_valid,
  input  logic                  rd_data_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [LW-1:0]         rd_len,
  input  logic                  inv_valid,
  output logic                  inv_ready,
  input  logic [SW-1:0]         inv_slot,
  output logic [CW-1:0]         free_count,
  output logic [NUM_SLOTS-1:0]  valid_mask
);

  localparam int unsigned PW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {S_FREE, S_WRITING, S_VALID, S_READING} slot_st_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_DRAIN} w_st_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_st_t;

  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS][MEM_DEPTH];

  slot_st_t       slot_st  [NUM_SLOTS];
  slot_st_t       slot_nxt [NUM_SLOTS];
  logic [LW-1:0]  slot_len [NUM_SLOTS];

  w_st_t          w_st;
  logic [SW-1:0]  wslot;
  logic [PW-1:0]  wptr;
  r_st_t          r_st;
  logic [SW-1:0]  rslot;
  logic [PW-1:0]  rptr;
  logic [PW-1:0]  rptr_inc;

  logic [SW-1:0]  free_slot;
  logic           wr_start_hs, wr_beat, wptr_last, wr_close;
  logic           rd_start_hs, rd_done, inv_hs;
  logic [CW-1:0]  cnt_nxt;
  logic [NUM_SLOTS-1:0] mask_nxt;

  // Lowest-index FREE slot (scan downward so the lowest match wins)
  always_comb begin
    free_slot = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (slot_st[i] == S_FREE) free_slot = SW'(i);
    end
  end

  assign wr_start_ready = (w_st == W_IDLE) && (free_count != '0);
  assign wr_start_slot  = free_slot;
  assign wr_data_ready  = (w_st != W_IDLE);
  assign rd_start_ready = (r_st == R_IDLE) && (slot_st[rd_start_slot] == S_VALID);
  // A same-cycle read start on the slot takes priority over invalidation
  assign inv_ready      = (slot_st[inv_slot] == S_VALID) &&
                          !(rd_start_hs && (rd_start_slot == inv_slot));

  assign wr_start_hs = wr_start_valid && wr_start_ready;
  assign wr_beat     = (w_st == W_DATA) && wr_data_valid;
  assign wptr_last   = (wptr == PW'(MEM_DEPTH - 1));
  assign wr_close    = wr_beat && (wr_last || wptr_last);
  assign rd_start_hs = rd_start_valid && rd_start_ready;
  assign rd_done     = (r_st == R_DATA) && rd_data_valid && rd_data_ready && rd_last;
  assign inv_hs      = inv_valid && inv_ready;
  assign rptr_inc    = rptr + PW'(1);

  // Slot next state; concurrent events always target distinct slots
  always_comb begin
    for (int i = 0; i < int'(NUM_SLOTS); i++) slot_nxt[i] = slot_st[i];
    if (wr_start_hs) slot_nxt[free_slot] = S_WRITING;
    if (wr_close)    slot_nxt[wslot]     = S_VALID;
    if (rd_start_hs) slot_nxt[rd_start_slot] = S_READING;
`ifdef PRT_AUTO_RELEASE_EN
    if (rd_done)     slot_nxt[rslot]     = S_FREE;
`else
    if (rd_done)     slot_nxt[rslot]     = S_VALID;
`endif
    if (inv_hs)      slot_nxt[inv_slot]  = S_FREE;
  end

  // Occupancy summary derived from next state so it lands with the slot update
  always_comb begin
    cnt_nxt  = '0;
    mask_nxt = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (slot_nxt[i] == S_FREE) cnt_nxt = cnt_nxt + CW'(1);
      mask_nxt[i] = (slot_nxt[i] == S_VALID) || (slot_nxt[i] == S_READING);
    end
  end

  // Slot table, lengths and summary registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        slot_st[i]  <= S_FREE;
        slot_len[i] <= '0;
      end
      free_count <= CW'(NUM_SLOTS);
      valid_mask <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) slot_st[i] <= slot_nxt[i];
      if (wr_close) slot_len[wslot] <= wr_last ? (LW'(wptr) + LW'(1)) : LW'(MEM_DEPTH);
      if (inv_hs)   slot_len[inv_slot] <= '0;
      free_count <= cnt_nxt;
      valid_mask <= mask_nxt;
    end
  end

  // Frame storage (not reset; invalidation only drops the slot state)
  always_ff @(posedge CLK) begin
    if (wr_beat) mem[wslot][wptr] <= wr_data;
  end

  // Write channel FSM
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      w_st        <= W_IDLE;
      wslot       <= '0;
      wptr        <= '0;
      wr_overflow <= 1'b0;
    end else begin
      wr_overflow <= 1'b0;
      case (w_st)
        W_IDLE: begin
          if (wr_start_hs) begin
            wslot <= free_slot;
            wptr  <= '0;
            w_st  <= W_DATA;
          end
        end
        W_DATA: begin
          if (wr_data_valid) begin
            if (wr_last) begin
              w_st <= W_IDLE;
            end else if (wptr_last) begin
              // Frame truncated at MEM_DEPTH: swallow the rest of it
              wr_overflow <= 1'b1;
              w_st        <= W_DRAIN;
            end else begin
              wptr <= wptr + PW'(1);
            end
          end
        end
        W_DRAIN: begin
          if (wr_data_valid && wr_last) w_st <= W_IDLE;
        end
        default: w_st <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM; rd_data is the synchronous memory read register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_st          <= R_IDLE;
      rslot         <= '0;
      rptr          <= '0;
      rd_len        <= '0;
      rd_data       <= '0;
      rd_last       <= 1'b0;
      rd_data_valid <= 1'b0;
    end else begin
      case (r_st)
        R_IDLE: begin
          if (rd_start_hs) begin
            rslot  <= rd_start_slot;
            rptr   <= '0;
            rd_len <= slot_len[rd_start_slot];
            r_st   <= R_FETCH;
          end
        end
        R_FETCH: begin
          rd_data       <= mem[rslot][rptr];
          rd_last       <= (rd_len == LW'(1));
          rd_data_valid <= 1'b1;
          r_st          <= R_DATA;
        end
        R_DATA: begin
          // Hold beat while stalled; prefetch the next beat on each handshake
          if (rd_data_ready) begin
            if (rd_last) begin
              rd_data_valid <= 1'b0;
              rd_last       <= 1'b0;
              r_st          <= R_IDLE;
            end else begin
              rptr    <= rptr_inc;
              rd_data <= mem[rslot][rptr_inc];
              rd_last <= ((LW'(rptr_inc) + LW'(1)) == rd_len);
            end
          end
        end
        default: r_st <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prt_dual_port.sv
// Directed testbench for prt_dual_port. A second instance with MEM_DEPTH=16
// shares all inputs and is used for the truncation scenario.
module tb_prt_dual_port;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       wr_start_valid = 0, wr_data_valid = 0, wr_last = 0;
  logic [7:0] wr_data = '0;
  logic       rd_start_valid = 0, rd_data_ready = 0, inv_valid = 0;
  logic [1:0] rd_start_slot = '0, inv_slot = '0;

  logic        wr_start_ready, wr_data_ready, wr_overflow, rd_start_ready;
  logic [1:0]  wr_start_slot;
  logic        rd_data_valid, rd_last, inv_ready;
  logic [7:0]  rd_data;
  logic [10:0] rd_len;
  logic [2:0]  free_count;
  logic [3:0]  valid_mask;

  logic        s_wr_start_ready, s_wr_data_ready, s_wr_overflow, s_rd_start_ready;
  logic [1:0]  s_wr_start_slot;
  logic        s_rd_data_valid, s_rd_last, s_inv_ready;
  logic [7:0]  s_rd_data;
  logic [4:0]  s_rd_len;
  logic [2:0]  s_free_count;
  logic [3:0]  s_valid_mask;

  int checks = 0;
  int errors = 0;

  prt_dual_port u_dut (
    .CLK(clk), .RST_N(rst_n),
    .wr_start_valid(wr_start_valid), .wr_start_ready(wr_start_ready), .wr_start_slot(wr_start_slot),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
    .wr_last(wr_last), .wr_overflow(wr_overflow),
    .rd_start_valid(rd_start_valid), .rd_start_ready(rd_start_ready), .rd_start_slot(rd_start_slot),
    .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
    .rd_last(rd_last), .rd_len(rd_len),
    .inv_valid(inv_valid), .inv_ready(inv_ready), .inv_slot(inv_slot),
    .free_count(free_count), .valid_mask(valid_mask)
  );

  prt_dual_port #(.MEM_DEPTH(16)) u_dut16 (
    .CLK(clk), .RST_N(rst_n),
    .wr_start_valid(wr_start_valid), .wr_start_ready(s_wr_start_ready), .wr_start_slot(s_wr_start_slot),
    .wr_data_valid(wr_data_valid), .wr_data_ready(s_wr_data_ready), .wr_data(wr_data),
    .wr_last(wr_last), .wr_overflow(s_wr_overflow),
    .rd_start_valid(rd_start_valid), .rd_start_ready(s_rd_start_ready), .rd_start_slot(rd_start_slot),
    .rd_data_valid(s_rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(s_rd_data),
    .rd_last(s_rd_last), .rd_len(s_rd_len),
    .inv_valid(inv_valid), .inv_ready(s_inv_ready), .inv_slot(inv_slot),
    .free_count(s_free_count), .valid_mask(s_valid_mask)
  );

  // Overflow pulse monitors (cycles seen high)
  int ovf_cnt = 0;
  int ovf16_cnt = 0;
  always @(negedge clk) begin
    if (rst_n && wr_overflow)   ovf_cnt++;
    if (rst_n && s_wr_overflow) ovf16_cnt++;
  end

  // Read capture results
  logic [7:0] rq[$];
  int         rlast_pos, rstall_bad, rfirst_valid;
  bit         rtimeout;
  logic       rvalid_after;

  task automatic clear_inputs();
    wr_start_valid = 0; wr_data_valid = 0; wr_last = 0; wr_data = '0;
    rd_start_valid = 0; rd_data_ready = 0; rd_start_slot = '0;
    inv_valid = 0; inv_slot = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_write(input int n, input logic [7:0] base, output logic [1:0] slot);
    int g;
    @(negedge clk);
    wr_start_valid = 1; #1;
    g = 0;
    while (!wr_start_ready && g < 100) begin @(negedge clk); #1; g++; end
    if (!wr_start_ready) begin
      checks++; errors++;
      $display("FAIL write_alloc_timeout: wr_start_ready=%0b required 1", wr_start_ready);
    end
    slot = wr_start_slot;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_start_valid = 0; wr_data_valid = 1;
      wr_data = base + 8'(i); wr_last = (i == n - 1);
    end
    @(negedge clk);
    wr_data_valid = 0; wr_last = 0;
  endtask

  task automatic do_read(input logic [1:0] slot, input bit toggle, input int maxcyc);
    int g, cyc;
    bit done, prev_stall;
    logic [7:0] pd;
    logic pl;
    rq.delete(); rlast_pos = -1; rstall_bad = 0; rfirst_valid = -1;
    @(negedge clk);
    rd_start_slot = slot; rd_start_valid = 1; #1;
    g = 0;
    while (!rd_start_ready && g < 100) begin @(negedge clk); #1; g++; end
    if (!rd_start_ready) begin
      checks++; errors++;
      $display("FAIL read_start_timeout: rd_start_ready=%0b required 1", rd_start_ready);
    end
    done = 0; cyc = 0; prev_stall = 0; pd = '0; pl = 0;
    while (!done && cyc < maxcyc) begin
      @(negedge clk);
      cyc++;
      rd_start_valid = 0;
      if (prev_stall && (rd_data !== pd || rd_last !== pl || rd_data_valid !== 1'b1)) rstall_bad++;
      rd_data_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (rd_data_valid && rfirst_valid < 0) rfirst_valid = cyc;
      if (rd_data_valid && rd_data_ready) begin
        rq.push_back(rd_data);
        if (rd_last) begin rlast_pos = rq.size() - 1; done = 1; end
      end
      prev_stall = rd_data_valid && !rd_data_ready;
      pd = rd_data; pl = rd_last;
    end
    rtimeout = !done;
    @(negedge clk);
    rd_data_ready = 0;
    rvalid_after = rd_data_valid;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk); #1;
    checks++; if (free_count !== 3'd4) begin errors++; $display("FAIL reset_free_count: got %0d want 4", free_count); end
    checks++; if (valid_mask !== 4'h0) begin errors++; $display("FAIL reset_valid_mask: got %h want 0", valid_mask); end
    checks++; if (rd_data_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== 8'h00) begin
      errors++; $display("FAIL reset_rd_outputs: valid=%b last=%b data=%h want 0 0 00", rd_data_valid, rd_last, rd_data); end
    checks++; if (rd_len !== 11'd0) begin errors++; $display("FAIL reset_rd_len: got %0d want 0", rd_len); end
    checks++; if (wr_data_ready !== 1'b0 || wr_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_wr_outputs: ready=%b ovf=%b want 0 0", wr_data_ready, wr_overflow); end
    checks++; if (inv_ready !== 1'b0 || rd_start_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: inv=%b rd_start=%b want 0 0", inv_ready, rd_start_ready); end
  endtask

  task automatic test_basic();
    logic [1:0] s;
    int bad;
    apply_reset();
    do_write(64, 8'h00, s); #1;
    checks++; if (s !== 2'd0) begin errors++; $display("FAIL basic_slot: got %0d want 0", s); end
    checks++; if (free_count !== 3'd3) begin errors++; $display("FAIL basic_free_count: got %0d want 3", free_count); end
    checks++; if (valid_mask !== 4'b0001) begin errors++; $display("FAIL basic_valid_mask: got %b want 0001", valid_mask); end
    do_read(2'd0, 1'b0, 200);
    bad = 0;
    foreach (rq[i]) if (rq[i] !== 8'(i)) bad++;
    checks++; if (rtimeout || rq.size() != 64) begin errors++; $display("FAIL basic_beats: got %0d timeout=%0b want 64", rq.size(), rtimeout); end
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_data: %0d wrong beats want 0", bad); end
    checks++; if (rlast_pos != 63) begin errors++; $display("FAIL basic_rd_last: at beat %0d want 63", rlast_pos); end
    checks++; if (rd_len !== 11'd64) begin errors++; $display("FAIL basic_rd_len: got %0d want 64", rd_len); end
    checks++; if (rfirst_valid != 2) begin errors++; $display("FAIL basic_latency: valid at cycle %0d want 2", rfirst_valid); end
    checks++; if (rvalid_after !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", rvalid_after); end
    #1;
`ifdef PRT_AUTO_RELEASE_EN
    checks++; if (valid_mask !== 4'b0000 || free_count !== 3'd4) begin
      errors++; $display("FAIL basic_release: mask=%b free=%0d want 0000 4", valid_mask, free_count); end
`else
    checks++; if (valid_mask !== 4'b0001 || free_count !== 3'd3) begin
      errors++; $display("FAIL basic_retain: mask=%b free=%0d want 0001 3", valid_mask, free_count); end
`endif
  endtask

  task automatic test_fill();
    logic [1:0] s0, s1, s2, s3;
    int bad;
    apply_reset();
    do_write(1, 8'hA0, s0);
    do_write(2, 8'hB0, s1);
    do_write(3, 8'hC0, s2);
    do_write(4, 8'hD0, s3); #1;
    checks++; if ({s3, s2, s1, s0} !== 8'b11_10_01_00) begin
      errors++; $display("FAIL fill_slots: got %0d %0d %0d %0d want 0 1 2 3", s0, s1, s2, s3); end
    checks++; if (wr_start_ready !== 1'b0 || free_count !== 3'd0 || valid_mask !== 4'hF) begin
      errors++; $display("FAIL fill_full: ready=%b free=%0d mask=%b want 0 0 1111", wr_start_ready, free_count, valid_mask); end
    @(negedge clk);
    inv_valid = 1; inv_slot = 2'd2; #1;
    checks++; if (inv_ready !== 1'b1 || wr_start_ready !== 1'b0) begin
      errors++; $display("FAIL fill_inv_cycle: inv_ready=%b wr_start_ready=%b want 1 0", inv_ready, wr_start_ready); end
    @(negedge clk);
    inv_valid = 0; #1;
    checks++; if (wr_start_ready !== 1'b1 || wr_start_slot !== 2'd2) begin
      errors++; $display("FAIL fill_realloc: ready=%b slot=%0d want 1 2", wr_start_ready, wr_start_slot); end
    checks++; if (free_count !== 3'd1 || valid_mask !== 4'b1011) begin
      errors++; $display("FAIL fill_after_inv: free=%0d mask=%b want 1 1011", free_count, valid_mask); end
    do_read(2'd3, 1'b0, 100);
    bad = (rq.size() != 4) ? 1 : 0;
    foreach (rq[i]) if (rq[i] !== 8'hD0 + 8'(i)) bad++;
    checks++; if (bad != 0 || rd_len !== 11'd4 || rlast_pos != 3) begin
      errors++; $display("FAIL fill_read_slot3: bad=%0d len=%0d last=%0d want 0 4 3", bad, rd_len, rlast_pos); end
  endtask

  task automatic test_concurrent();
    logic [1:0] s, s1;
    int bad;
    apply_reset();
    do_write(64, 8'h00, s);
    fork
      do_read(2'd0, 1'b1, 400);
      do_write(40, 8'h80, s1);
    join
    bad = 0;
    foreach (rq[i]) if (rq[i] !== 8'(i)) bad++;
    checks++; if (rtimeout || rq.size() != 64 || bad != 0) begin
      errors++; $display("FAIL conc_read: beats=%0d bad=%0d timeout=%0b want 64 0 0", rq.size(), bad, rtimeout); end
    checks++; if (rstall_bad != 0) begin errors++; $display("FAIL conc_stall_stable: %0d changes want 0", rstall_bad); end
    checks++; if (rlast_pos != 63) begin errors++; $display("FAIL conc_rd_last: at %0d want 63", rlast_pos); end
    checks++; if (s1 !== 2'd1) begin errors++; $display("FAIL conc_wr_slot: got %0d want 1", s1); end
    do_read(2'd1, 1'b0, 200);
    bad = 0;
    foreach (rq[i]) if (rq[i] !== 8'h80 + 8'(i)) bad++;
    checks++; if (rq.size() != 40 || bad != 0 || rd_len !== 11'd40) begin
      errors++; $display("FAIL conc_slot1: beats=%0d bad=%0d len=%0d want 40 0 40", rq.size(), bad, rd_len); end
  endtask

  task automatic test_inv_rules();
    logic [1:0] s;
    int g;
    apply_reset();
    do_write(8, 8'h20, s);
    @(negedge clk);
    rd_start_slot = 2'd0; rd_start_valid = 1; inv_valid = 1; inv_slot = 2'd0; #1;
    checks++; if (rd_start_ready !== 1'b1 || inv_ready !== 1'b0) begin
      errors++; $display("FAIL inv_read_wins: rd_start_ready=%b inv_ready=%b want 1 0", rd_start_ready, inv_ready); end
    @(negedge clk);
    rd_start_valid = 0; rd_data_ready = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (inv_ready !== 1'b0) begin errors++; $display("FAIL inv_reading_stall: cycle %0d inv_ready=%b want 0", k, inv_ready); end
      @(negedge clk);
    end
    rd_data_ready = 1;
    g = 0;
    while (!(rd_data_valid && rd_last) && g < 50) begin @(negedge clk); g++; end
    #1;
    checks++; if (!(rd_data_valid && rd_last) || inv_ready !== 1'b0) begin
      errors++; $display("FAIL inv_at_last_beat: last=%b inv_ready=%b want 1 0", rd_last, inv_ready); end
    @(negedge clk); #1;
`ifdef PRT_AUTO_RELEASE_EN
    checks++; if (inv_ready !== 1'b0) begin errors++; $display("FAIL inv_after_release: inv_ready=%b want 0", inv_ready); end
`else
    checks++; if (inv_ready !== 1'b1) begin errors++; $display("FAIL inv_after_read: inv_ready=%b want 1", inv_ready); end
`endif
    checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL inv_valid_drop: got %b want 0", rd_data_valid); end
    @(negedge clk);
    inv_valid = 0; rd_data_ready = 0; #1;
    checks++; if (valid_mask !== 4'b0000 || free_count !== 3'd4) begin
      errors++; $display("FAIL inv_freed: mask=%b free=%0d want 0000 4", valid_mask, free_count); end
  endtask

  task automatic test_overflow();
    logic [1:0] s;
    logic [7:0] q[$];
    int o16, om, g, bad;
    bit done;
    apply_reset();
    o16 = ovf16_cnt; om = ovf_cnt;
    do_write(20, 8'h40, s);
    @(negedge clk); #1;
    checks++; if (ovf16_cnt - o16 != 1) begin errors++; $display("FAIL ovf_pulse16: %0d cycles high want 1", ovf16_cnt - o16); end
    checks++; if (ovf_cnt - om != 0) begin errors++; $display("FAIL ovf_pulse_full: %0d cycles high want 0", ovf_cnt - om); end
    checks++; if (s_wr_start_ready !== 1'b1 || s_valid_mask !== 4'b0001) begin
      errors++; $display("FAIL ovf_state: ready=%b mask=%b want 1 0001", s_wr_start_ready, s_valid_mask); end
    rd_start_slot = 2'd0; rd_start_valid = 1; #1;
    checks++; if (s_rd_start_ready !== 1'b1) begin errors++; $display("FAIL ovf_rd_start: got %b want 1", s_rd_start_ready); end
    done = 0; g = 0;
    while (!done && g < 100) begin
      @(negedge clk);
      g++;
      rd_start_valid = 0; rd_data_ready = 1;
      if (s_rd_data_valid) begin
        q.push_back(s_rd_data);
        if (s_rd_last) done = 1;
      end
    end
    bad = 0;
    foreach (q[i]) if (q[i] !== 8'h40 + 8'(i)) bad++;
    checks++; if (!done || q.size() != 16 || bad != 0) begin
      errors++; $display("FAIL ovf_read: done=%0b beats=%0d bad=%0d want 1 16 0", done, q.size(), bad); end
    checks++; if (s_rd_len !== 5'd16 || rd_len !== 11'd20) begin
      errors++; $display("FAIL ovf_rd_len: d16=%0d full=%0d want 16 20", s_rd_len, rd_len); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] s;
    apply_reset();
    do_write(64, 8'h00, s);
    @(negedge clk);
    rd_start_slot = 2'd0; rd_start_valid = 1;
    @(negedge clk);
    rd_start_valid = 0; rd_data_ready = 0; wr_start_valid = 1;
    @(negedge clk);
    wr_start_valid = 0; wr_data_valid = 1; wr_data = 8'h55;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rd_data_valid !== 1'b1 || wr_data_ready !== 1'b1 || free_count !== 3'd2) begin
      errors++; $display("FAIL mid_pre_reset: rd_valid=%b wr_ready=%b free=%0d want 1 1 2", rd_data_valid, wr_data_ready, free_count); end
    rst_n = 1'b0; #1;
    checks++; if (rd_data_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== 8'h00 || rd_len !== 11'd0) begin
      errors++; $display("FAIL mid_reset_rd: valid=%b last=%b data=%h len=%0d want 0 0 00 0", rd_data_valid, rd_last, rd_data, rd_len); end
    checks++; if (wr_data_ready !== 1'b0 || wr_overflow !== 1'b0) begin
      errors++; $display("FAIL mid_reset_wr: ready=%b ovf=%b want 0 0", wr_data_ready, wr_overflow); end
    checks++; if (free_count !== 3'd4 || valid_mask !== 4'h0 || rd_start_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_slots: free=%0d mask=%b rd_start_ready=%b want 4 0000 0", free_count, valid_mask, rd_start_ready); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1; #1;
    checks++; if (wr_start_ready !== 1'b1 || wr_start_slot !== 2'd0) begin
      errors++; $display("FAIL mid_post_reset: ready=%b slot=%0d want 1 0", wr_start_ready, wr_start_slot); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_concurrent();
    test_inv_rules();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
